// File: rtl/amber48_fetch.sv
// amber48 instruction fetch: credit-limited request issue, in-order response FIFO, redirect drain.
// Optional performance counters are built when AMBER48_FETCH_PERF_EN is defined.
package amber48_pkg;
    localparam int XLEN = 48;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } amber48_decode_in_s;
endpackage

module amber48_fetch
    import amber48_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 48'h0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [XLEN-1:0]    imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output amber48_decode_in_s fetch_o,
    input  logic               fetch_ready
`ifdef AMBER48_FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] buf_pc_mem    [BUF_DEPTH];
    logic [XLEN-1:0] buf_instr_mem [BUF_DEPTH];

    logic            req_fire;
    logic            push;
    logic            pop;
    logic            fetch_valid;
    logic [CW:0]     credit_used;
    logic [CW-1:0]   remaining;
    logic [XLEN-1:0] rsp_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && (state_q == RUN) && (credit_used < (CW+1)'(BUF_DEPTH))
                            && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign fetch_valid    = (count_q != '0) && !redirect_valid;
    assign pop            = fetch_valid && fetch_ready;
    assign remaining      = outstanding_q - CW'(imem_rsp_valid);
    // Requests since the last redirect are consecutive, so the oldest one sits outstanding words behind pc.
    assign rsp_pc         = pc_q - XLEN'(outstanding_q);

    always_comb begin
        fetch_o = '0;
        if (fetch_valid) begin
            fetch_o.valid = 1'b1;
            fetch_o.pc    = buf_pc_mem[rd_ptr_q];
            fetch_o.instr = buf_instr_mem[rd_ptr_q];
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        push          = 1'b0;
        if (req_fire) begin
            pc_d = pc_q + XLEN'(1);
        end
        unique case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    count_d       = '0;
                    wr_ptr_d      = '0;
                    rd_ptr_d      = '0;
                    outstanding_d = '0;
                    if (remaining != '0) begin
                        state_d = DRAIN;
                        drop_d  = remaining;
                    end
                end else begin
                    push          = imem_rsp_valid;
                    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
                    count_d       = count_q + CW'(push) - CW'(pop);
                    if (push) begin
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end
                    if (pop) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    drop_d = drop_q - CW'(1);
                    if (drop_q == CW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_mem[wr_ptr_q]    <= rsp_pc;
            buf_instr_mem[wr_ptr_q] <= imem_rsp_data;
        end
    end

`ifdef AMBER48_FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        if (pop && (perf_fetched_q != '1)) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (fetch_ready && !fetch_valid && (perf_bubbles_q != '1)) begin
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_amber48_fetch.sv
// Randomized bench for amber48_fetch: a queue-level reference of memory, in-flight requests and
// the delivery buffer predicts every output each cycle; directed phases cover reset, stall and redirects.
module tb_amber48_fetch;
    import amber48_pkg::*;

    localparam int              DEPTH  = 3;
    localparam logic [47:0]     RST_PC = 48'h100;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               imem_req_valid;
    logic               imem_req_ready = 1'b0;
    logic [47:0]        imem_req_addr;
    logic               imem_rsp_valid = 1'b0;
    logic [47:0]        imem_rsp_data  = '0;
    logic               redirect_valid = 1'b0;
    logic [47:0]        redirect_pc    = '0;
    amber48_decode_in_s fetch_o;
    logic               fetch_ready    = 1'b0;
`ifdef AMBER48_FETCH_PERF_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_bubbles;
`endif

    amber48_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_o        (fetch_o),
        .fetch_ready    (fetch_ready)
`ifdef AMBER48_FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] addr;
        int          due;
        bit          stale;
    } infl_t;

    infl_t       mq[$];
    logic [47:0] fq[$];
    logic [47:0] m_pc;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          fires;
    int          first_valid_cyc;
    bit          watch_redir;
    logic [47:0] redir_seen_pc;
    int          m_perf_f;
    int          m_perf_b;

    int          lat_lo = 1, lat_hi = 1;
    int          p_ready = 100, p_fready = 100, p_redir = 0;
    bit          force_redir = 1'b0;
    logic [47:0] force_pc = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [47:0] mem_word(input logic [47:0] a);
        return {a[23:0], a[47:24]} ^ 48'h5A5A_A5A5_0F0F;
    endfunction

    function automatic logic [47:0] rand_pc();
        logic [47:0] r;
        r = {16'($urandom), $urandom};
        if ($urandom_range(3, 0) == 0) begin
            r = 48'hFFFF_FFFF_FFFC + 48'($urandom_range(3, 0));
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        fetch_ready    = 1'b0;
        imem_req_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_req_valid", 128'(imem_req_valid), 128'(0));
            chk("rst_fetch_o", 128'(fetch_o), 128'(0));
        end
        mq.delete();
        fq.delete();
        m_pc            = RST_PC;
        cyc             = 0;
        first_valid_cyc = -1;
        m_perf_f        = 0;
        m_perf_b        = 0;
    endtask

    task automatic step();
        bit    rsp_now, stale_any, exp_rv, exp_fv;
        int    due;
        infl_t h;
        @(negedge clk);
        rst            = 1'b0;
        rsp_now        = (mq.size() > 0) && (mq[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq[0].addr) : {16'($urandom), $urandom};
        imem_req_ready = ($urandom_range(99, 0) < p_ready);
        fetch_ready    = ($urandom_range(99, 0) < p_fready);
        redirect_valid = force_redir || ($urandom_range(99, 0) < p_redir);
        redirect_pc    = force_redir ? force_pc : rand_pc();
        #1;
        stale_any = 1'b0;
        foreach (mq[i]) if (mq[i].stale) stale_any = 1'b1;
        exp_rv = !stale_any && (mq.size() + fq.size() < DEPTH) && !redirect_valid;
        exp_fv = (fq.size() > 0) && !redirect_valid;
        chk("req_valid", 128'(imem_req_valid), 128'(exp_rv));
        if (exp_rv) chk("req_addr", 128'(imem_req_addr), 128'(m_pc));
        chk("fetch_valid", 128'(fetch_o.valid), 128'(exp_fv));
        if (exp_fv) begin
            chk("fetch_pc", 128'(fetch_o.pc), 128'(fq[0]));
            chk("fetch_instr", 128'(fetch_o.instr), 128'(mem_word(fq[0])));
        end
`ifdef AMBER48_FETCH_PERF_EN
        chk("perf_fetched", 128'(perf_fetched), 128'(m_perf_f));
        chk("perf_bubbles", 128'(perf_bubbles), 128'(m_perf_b));
`endif
        if (fetch_o.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (fetch_o.valid && watch_redir) begin
            redir_seen_pc = fetch_o.pc;
            watch_redir   = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) fires++;
        if (exp_fv && fetch_ready) begin
            $display("[TB] cyc %0d fetch pc=%012h instr=%012h", cyc, fq[0], mem_word(fq[0]));
            void'(fq.pop_front());
            m_perf_f++;
        end
        if (fetch_ready && !exp_fv) m_perf_b++;
        if (rsp_now) begin
            h = mq.pop_front();
            if (!redirect_valid && !h.stale) fq.push_back(h.addr);
        end
        if (redirect_valid) begin
            fq.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_pc = redirect_pc;
            if (force_redir) watch_redir = 1'b1;
        end else if (exp_rv && imem_req_ready) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
            mq.push_back('{addr: m_pc, due: due, stale: 1'b0});
            m_pc = m_pc + 48'd1;
        end
        cyc++;
    endtask

    initial begin
        watch_redir   = 1'b0;
        redir_seen_pc = '0;
        fires         = 0;

        // Latency-1 streaming from reset
        do_reset();
        repeat (20) step();
        chk("first_valid_cyc", 128'(first_valid_cyc), 128'(2));

        // Mid-operation reset, then decode stalled for 10 cycles
        do_reset();
        p_fready = 0;
        fires    = 0;
        repeat (10) step();
        chk("stall_issued", 128'(fires), 128'(DEPTH));
        chk("stall_req_valid", 128'(imem_req_valid), 128'(0));
        p_fready = 100;
        repeat (10) step();

        // Latency 3, redirect with requests in flight
        lat_lo = 3; lat_hi = 3;
        repeat (8) step();
        force_redir = 1'b1; force_pc = 48'h200;
        step();
        force_redir = 1'b0;
        repeat (12) step();
        chk("redir_next_pc", 128'(redir_seen_pc), 128'(48'h200));

        // Memory not ready for 5 cycles at PC 0x10
        lat_lo = 1; lat_hi = 1;
        force_redir = 1'b1; force_pc = 48'h10;
        step();
        force_redir = 1'b0;
        repeat (4) step();
        p_ready = 0;
        repeat (5) step();
        p_ready = 100;
        repeat (6) step();

        // Random traffic
        lat_lo = 1; lat_hi = 4;
        p_ready = 70; p_fready = 70; p_redir = 6;
        repeat (3000) step();
        p_redir = 0; p_ready = 100; p_fready = 100;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
